// File: rtl/seg7_scan_to_bcd.sv
// seg7_scan_to_bcd: decodes a multiplexed 7-segment bus back to packed BCD.
// Debounces each strobed digit, assembles full frames, flags bad digits.
module seg7_scan_to_bcd #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:6]            seg,
  input  logic [DIGITS-1:0]     dig,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  err,
  output logic [DIGITS-1:0]     digit_bad
);

  localparam int CW = 4;
  localparam logic [CW-1:0] STB = CW'(STABLE);

  logic [0:6]          prev_seg;
  logic [DIGITS-1:0]   prev_dig;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                one_hot;
  logic                same;
  logic                capture;
  logic [DIGITS-1:0]   cap_mask;

  logic [3:0]          dec_val;
  logic                dec_ok;

  logic [4*DIGITS-1:0] staging;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   bad;
  logic [DIGITS-1:0]   seen_base;
  logic [DIGITS-1:0]   bad_base;
  logic [DIGITS-1:0]   seen_nxt;
  logic [DIGITS-1:0]   bad_nxt;
  logic                frame_done;

  assign one_hot    = $onehot(dig);
  assign same       = (seg == prev_seg) && (dig == prev_dig);
  assign frame_done = &seen;

  // Hold counter: run length of an identical one-hot sample, saturating.
  always_comb begin
    cnt_nxt = '0;
    if (one_hot) begin
      if (!same)
        cnt_nxt = CW'(1);
      else if (cnt == STB)
        cnt_nxt = cnt;
      else
        cnt_nxt = cnt + CW'(1);
    end
  end

  // A capture fires only on the edge the count first reaches STABLE.
  assign capture  = one_hot && (cnt_nxt == STB) && (cnt != STB);
  assign cap_mask = capture ? dig : '0;

  // Strict segment decode; anything outside the ten glyphs is invalid.
  always_comb begin
    dec_val = 4'd0;
    dec_ok  = 1'b1;
    case (seg)
      7'b1111110: dec_val = 4'd0;
      7'b0110000: dec_val = 4'd1;
      7'b1101101: dec_val = 4'd2;
      7'b1111001: dec_val = 4'd3;
      7'b0110011: dec_val = 4'd4;
      7'b1011011: dec_val = 4'd5;
      7'b1011111: dec_val = 4'd6;
      7'b1110000: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1110011: dec_val = 4'd9;
      default: begin
        dec_val = 4'd0;
        dec_ok  = 1'b0;
      end
    endcase
  end

  // Frame masks: completion clears first, a same-edge capture lands after.
  always_comb begin
    seen_base = frame_done ? '0 : seen;
    bad_base  = frame_done ? '0 : bad;
    seen_nxt  = seen_base | cap_mask;
    bad_nxt   = (bad_base & ~cap_mask)
              | (dec_ok ? '0 : cap_mask);
  end

  // Sample register and debounce counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_seg <= '0;
      prev_dig <= '0;
      cnt      <= '0;
    end else begin
      prev_seg <= seg;
      prev_dig <= dig;
      cnt      <= cnt_nxt;
    end
  end

  // Staging digits: the captured digit slot takes the decoded value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging <= '0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (cap_mask[i])
          staging[4*i +: 4] <= dec_ok ? dec_val : 4'd0;
      end
    end
  end

  // Seen and bad masks for the frame under assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen <= '0;
      bad  <= '0;
    end else begin
      seen <= seen_nxt;
      bad  <= bad_nxt;
    end
  end

  // Frame result: publish a good frame or report the failing digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd       <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
      digit_bad <= '0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (frame_done) begin
        if (bad == '0) begin
          bcd       <= staging;
          valid     <= 1'b1;
          digit_bad <= '0;
        end else begin
          err       <= 1'b1;
          digit_bad <= bad;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// tb_seg7_scan_to_bcd: directed and random scans of a 4-digit bus,
// compared each cycle against a run-length/frame reference model.
module tb_seg7_scan_to_bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:6]  seg;
  logic [3:0]  dig;
  logic [15:0] bcd;
  logic        valid;
  logic        err;
  logic [3:0]  digit_bad;

  seg7_scan_to_bcd #(.DIGITS(4), .STABLE(3)) dut (
    .clk(clk), .reset(reset), .seg(seg), .dig(dig),
    .bcd(bcd), .valid(valid), .err(err), .digit_bad(digit_bad)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] pat [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
  };

  // reference model state
  int         run;
  logic [6:0] pseg;
  logic [3:0] pdig;
  int         m_stage [4];
  logic [3:0] m_seen, m_bad;
  bit         pend;
  logic [15:0] m_bcd;
  logic       m_valid, m_err;
  logic [3:0] m_dbad;

  int         nv, ne;
  logic [3:0] last_bad;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    run = 0; pseg = '0; pdig = '0;
    for (int k = 0; k < 4; k++) m_stage[k] = 0;
    m_seen = '0; m_bad = '0; pend = 0;
    m_bcd = '0; m_valid = 0; m_err = 0; m_dbad = '0;
  endtask

  task automatic m_step(input logic [6:0] s, input logic [3:0] d);
    int i;
    int v;
    m_valid = 0; m_err = 0;
    if (pend) begin
      if (m_bad == 0) begin
        for (int k = 0; k < 4; k++) m_bcd[4*k +: 4] = 4'(m_stage[k]);
        m_valid = 1; m_dbad = 0;
      end else begin
        m_err = 1; m_dbad = m_bad;
      end
      m_seen = 0; m_bad = 0; pend = 0;
    end
    if ($onehot(d)) run = (s == pseg && d == pdig) ? run + 1 : 1;
    else run = 0;
    pseg = s; pdig = d;
    if (run == 3) begin
      i = 0; v = -1;
      for (int k = 0; k < 4; k++) if (d[k]) i = k;
      for (int k = 0; k < 10; k++) if (pat[k] == s) v = k;
      m_stage[i] = (v < 0) ? 0 : v;
      m_seen[i] = 1'b1;
      m_bad[i]  = (v < 0);
    end
    if (m_seen == 4'hF) pend = 1;
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] d);
    @(negedge clk);
    seg = s; dig = d;
    @(posedge clk);
    m_step(s, d);
    #1;
    chk("bcd", bcd, m_bcd);
    chk("valid", valid, m_valid);
    chk("err", err, m_err);
    chk("digit_bad", digit_bad, m_dbad);
    chk("excl", valid & err, 1'b0);
    if (valid) nv++;
    if (err) begin ne++; last_bad = digit_bad; end
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d,
                      input int n, input int blank);
    for (int k = 0; k < n; k++) step(s, d);
    for (int k = 0; k < blank; k++) step(7'b0, 4'b0);
  endtask

  task automatic clr_cnt();
    nv = 0; ne = 0; last_bad = '0;
  endtask

  logic [6:0] rs;
  logic [3:0] rd;

  initial begin
    reset = 1'b1; seg = '0; dig = '0;
    m_reset();
    clr_cnt();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd", bcd, 16'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_dbad", digit_bad, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    // good scan of 4,3,2,1
    clr_cnt();
    hold(pat[4], 4'b0001, 4, 1);
    hold(pat[3], 4'b0010, 4, 1);
    hold(pat[2], 4'b0100, 4, 1);
    hold(pat[1], 4'b1000, 4, 1);
    chk("s1_bcd", bcd, 16'h1234);
    chk("s1_nvalid", nv, 1);
    chk("s1_nerr", ne, 0);

    // digit 2 undecodable
    clr_cnt();
    hold(pat[4], 4'b0001, 4, 1);
    hold(pat[3], 4'b0010, 4, 1);
    hold(7'b0000001, 4'b0100, 4, 1);
    hold(pat[1], 4'b1000, 4, 1);
    chk("s2_bcd", bcd, 16'h1234);
    chk("s2_nvalid", nv, 0);
    chk("s2_nerr", ne, 1);
    chk("s2_bad", last_bad, 4'b0100);

    // digit 0 too short, then re-held
    clr_cnt();
    hold(pat[5], 4'b0001, 2, 1);
    hold(pat[6], 4'b0010, 4, 1);
    hold(pat[7], 4'b0100, 4, 1);
    hold(pat[8], 4'b1000, 4, 1);
    chk("s3_short", nv + ne, 0);
    hold(pat[5], 4'b0001, 3, 2);
    chk("s3_nvalid", nv, 1);
    chk("s3_bcd", bcd, 16'h8765);

    // multi-hot strobe never captured
    clr_cnt();
    hold(pat[9], 4'b0011, 10, 1);
    hold(pat[1], 4'b0010, 4, 1);
    hold(pat[2], 4'b0100, 4, 1);
    hold(pat[3], 4'b1000, 4, 1);
    chk("s4_nocap", nv + ne, 0);
    hold(pat[0], 4'b0001, 4, 1);
    chk("s4_nvalid", nv, 1);
    chk("s4_bcd", bcd, 16'h3210);

    // recapture of digit 1 before completion
    clr_cnt();
    hold(pat[5], 4'b0010, 4, 1);
    hold(pat[0], 4'b0001, 4, 1);
    hold(pat[7], 4'b0010, 4, 1);
    hold(pat[9], 4'b0100, 4, 1);
    hold(pat[2], 4'b1000, 4, 1);
    chk("s5_nvalid", nv, 1);
    chk("s5_d1", bcd[7:4], 4'h7);
    chk("s5_bcd", bcd, 16'h2970);

    // asynchronous reset mid-frame
    clr_cnt();
    hold(pat[1], 4'b0001, 4, 1);
    hold(pat[2], 4'b0010, 4, 1);
    hold(pat[3], 4'b0100, 4, 1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("s6_rst_bcd", bcd, 16'h0);
    chk("s6_rst_valid", valid, 1'b0);
    chk("s6_rst_dbad", digit_bad, 4'h0);
    m_reset();
    #1 reset = 1'b0;
    hold(pat[4], 4'b1000, 4, 1);
    hold(pat[5], 4'b0001, 4, 1);
    hold(pat[6], 4'b0010, 4, 1);
    chk("s6_nopulse", nv + ne, 0);
    hold(pat[7], 4'b0100, 4, 1);
    chk("s6_nvalid", nv, 1);
    chk("s6_bcd", bcd, 16'h4765);

    // random scans
    clr_cnt();
    for (int t = 0; t < 400; t++) begin
      rd = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) rd = 4'($urandom);
      rs = pat[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) rs = 7'($urandom);
      hold(rs, rd, $urandom_range(1, 5), $urandom_range(0, 2));
    end
    chk("rnd_frames", (nv + ne) > 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_to_bcd.md
Name: seg7_scan_to_bcd

Overview:
Receive-side counterpart of the team's BCD-to-7-segment encoder. Monitors a time-multiplexed 7-segment display bus (segment lines plus one-hot digit strobes), debounces each strobed pattern and decodes it back to BCD. Assembles a full multi-digit frame and presents it as packed BCD with a valid pulse, or flags the offending digits with an error pulse. Used for display loopback self-test and for reading external segment-driven instruments.

Parameters:
DIGITS, 4, number of multiplexed digit positions (2..8)
STABLE, 3, consecutive clock edges an identical (seg,dig) pair must be held before capture (2..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
seg  input  [0:6]  segment lines, seg[0]=a .. seg[6]=g, active-high, same encoding as the encoder
dig  input  [DIGITS-1:0]  digit strobes, active-high, dig[0] = least significant digit
bcd  output  [4*DIGITS-1:0]  last good frame, bcd[3:0] = digit 0
valid  output  1  one-cycle pulse: bcd updated with a new good frame
err  output  1  one-cycle pulse: frame completed with at least one undecodable digit
digit_bad  output  [DIGITS-1:0]  per-digit failure map, updated together with err

Behaviour:
- One clock domain; reset is asynchronous and active-high, deasserted synchronously by the system.
- Reset values: bcd=0, valid=0, err=0, digit_bad=0; hold counter, previous-sample register, staging digits, seen/bad masks all cleared. Reset mid-frame discards the partial frame; no output pulse.
- Sampling: each edge registers (seg,dig). If the sample equals the previous sample and dig is exactly one-hot, hold counter increments, saturating at STABLE; otherwise counter = 1 for a one-hot sample, 0 for a non-one-hot sample.
- dig all-zero or multi-hot = blanking/glitch: never captured, resets counter.
- Capture: on the edge where the counter reaches STABLE (an identical one-hot pair sampled on STABLE consecutive edges). Exactly one capture per continuous hold; saturation prevents re-capture.
- Decode, strict: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1110011=9. Any other pattern, including all-off, is invalid.
- On capture of digit i: staging[i] = decoded value (0 if invalid); seen[i]=1; bad[i]=1 if invalid, else 0. Re-capture of a digit before the frame completes overwrites staging[i] and bad[i] (latest wins).
- Frame completion: the edge after seen becomes all-ones.
  - If bad==0: bcd <= staging, valid=1 for one cycle, digit_bad <= 0.
  - Else: err=1 for one cycle, digit_bad <= bad, bcd holds its previous value.
  - seen and bad clear on the same edge. A capture arriving on that edge is applied after the clear and starts the next frame.
- Latency: last digit held from edge e1 -> captured at e(STABLE) -> valid/err high after edge e(STABLE+1).
- Scan order is free: digits may arrive in any order, with any blanking gaps between them.
- valid and err are never high in the same cycle.

Test Plan:
DIGITS=4, STABLE=3. Strobe dig=0001..1000 with patterns for 4,3,2,1, each held 4 cycles with 1 blank cycle between -> single valid pulse one cycle after digit 3 capture, bcd=16'h1234, err=0.
Same scan, but digit 2 driven with 0000001 -> err pulse, digit_bad=4'b0100, bcd unchanged (16'h1234), no valid.
Digit 0 held only 2 cycles, then blanked -> no capture, no frame. Re-held 3 cycles -> frame completes normally.
Two strobes asserted at once (dig=0011) for 10 cycles -> no capture. Counter stays 0.
Digit 1 captured as 5, then recaptured as 7 before the frame completes -> resulting bcd[7:4]=4'h7.
Reset asserted after 3 of 4 digits are captured -> outputs zero immediately (asynchronous). Subsequent single digit captures produce no pulse until all 4 digits are seen again.
